// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: drives PC, F/D and D/A buffer enables plus bubble/flush strobes.
// Resolves load-use stalls, taken-branch flushes, HLT and interrupt entry (drain, PC push, vector).
//
// state | meaning
// RUN   | normal issue; branch, interrupt, hazard and HLT are checked here in that order
// LU    | extra load-use bubble cycles while the load completes
// HALT  | fetch frozen after HLT; only an interrupt request leaves
// DRAIN | in-flight instructions retire before the interrupt push
// PUSH  | memory stage pushes the PC words, one per cycle
// VEC   | PC loads the interrupt vector and the request is acknowledged
module pipe_hazard_ctrl #(
   parameter int LU_STALL     = 1,
   parameter int DRAIN_CYCLES = 3,
   parameter int INT_CYCLES   = 2,
   parameter int CNT_W        = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] i_dec_Rsrc1,
   input  logic [2:0] i_dec_Rsrc2,
   input  logic       i_dec_use1,
   input  logic       i_dec_use2,
   input  logic       i_alu_memrd,
   input  logic [2:0] i_alu_Rdst,
   input  logic       i_branch_taken,
   input  logic       i_hlt,
   input  logic       i_int_req,
   output logic       o_pc_enable,
   output logic [1:0] o_pc_sel,
   output logic       o_fd_enable,
   output logic       o_fd_flush,
   output logic       o_da_enable,
   output logic       o_da_bubble,
   output logic       o_int_step,
   output logic       o_int_ack,
   output logic [2:0] o_state
);

   typedef enum logic [2:0] {
      S_RUN   = 3'd0,
      S_LU    = 3'd1,
      S_HALT  = 3'd2,
      S_DRAIN = 3'd3,
      S_PUSH  = 3'd4,
      S_VEC   = 3'd5
   } state_t;

   localparam logic [1:0] SEL_INC  = 2'b00;
   localparam logic [1:0] SEL_BR   = 2'b01;
   localparam logic [1:0] SEL_VEC  = 2'b10;
   localparam logic [1:0] SEL_HOLD = 2'b11;

   // LU_STALL of 1 never enters LU, so its load value is irrelevant there
   localparam logic [CNT_W-1:0] LU_LOAD    = (LU_STALL > 1) ? CNT_W'(LU_STALL - 2) : '0;
   localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] INT_LOAD   = CNT_W'(INT_CYCLES - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_cnt_dec;
   logic             w_hazard;
   logic             w_cnt_zero;

   assign w_hazard   = i_alu_memrd &
                       ((i_dec_use1 & (i_dec_Rsrc1 == i_alu_Rdst)) |
                        (i_dec_use2 & (i_dec_Rsrc2 == i_alu_Rdst)));
   assign w_cnt_zero = (r_cnt == '0);
   assign w_cnt_dec  = w_cnt_zero ? '0 : (r_cnt - CNT_W'(1));
   assign o_state    = r_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      o_pc_enable = 1'b1;
      o_pc_sel    = SEL_INC;
      o_fd_enable = 1'b1;
      o_fd_flush  = 1'b0;
      o_da_enable = 1'b1;
      o_da_bubble = 1'b0;
      o_int_step  = 1'b0;
      o_int_ack   = 1'b0;

      case (r_state)
         S_RUN: begin
            if (i_branch_taken) begin
               o_pc_sel    = SEL_BR;
               o_fd_flush  = 1'b1;
               o_da_bubble = 1'b1;
            end else if (i_int_req) begin
               o_pc_enable = 1'b0;
               o_fd_flush  = 1'b1;
               w_state_nxt = S_DRAIN;
               w_cnt_nxt   = DRAIN_LOAD;
            end else if (w_hazard) begin
               o_pc_enable = 1'b0;
               o_fd_enable = 1'b0;
               o_da_bubble = 1'b1;
               if (LU_STALL > 1) begin
                  w_state_nxt = S_LU;
                  w_cnt_nxt   = LU_LOAD;
               end
            end else if (i_hlt) begin
               o_pc_enable = 1'b0;
               o_fd_flush  = 1'b1;
               w_state_nxt = S_HALT;
            end
         end

         S_LU: begin
            if (i_branch_taken) begin
               o_pc_sel    = SEL_BR;
               o_fd_flush  = 1'b1;
               o_da_bubble = 1'b1;
               w_state_nxt = S_RUN;
               w_cnt_nxt   = '0;
            end else begin
               o_pc_enable = 1'b0;
               o_pc_sel    = SEL_HOLD;
               o_fd_enable = 1'b0;
               o_da_bubble = 1'b1;
               w_cnt_nxt   = w_cnt_dec;
               if (w_cnt_zero) w_state_nxt = S_RUN;
            end
         end

         S_HALT: begin
            o_pc_enable = 1'b0;
            o_pc_sel    = SEL_HOLD;
            o_fd_flush  = 1'b1;
            o_da_bubble = 1'b1;
            if (i_int_req) begin
               w_state_nxt = S_DRAIN;
               w_cnt_nxt   = DRAIN_LOAD;
            end
         end

         S_DRAIN: begin
            // a late taken branch lands in the PC so its target is what gets pushed
            o_pc_enable = i_branch_taken;
            o_pc_sel    = i_branch_taken ? SEL_BR : SEL_HOLD;
            o_fd_flush  = 1'b1;
            o_da_bubble = 1'b1;
            if (w_cnt_zero) begin
               w_state_nxt = S_PUSH;
               w_cnt_nxt   = INT_LOAD;
            end else begin
               w_cnt_nxt   = w_cnt_dec;
            end
         end

         S_PUSH: begin
            o_int_step  = 1'b1;
            o_pc_enable = 1'b0;
            o_pc_sel    = SEL_HOLD;
            o_fd_flush  = 1'b1;
            o_da_bubble = 1'b1;
            w_cnt_nxt   = w_cnt_dec;
            if (w_cnt_zero) w_state_nxt = S_VEC;
         end

         S_VEC: begin
            o_pc_sel    = SEL_VEC;
            o_int_ack   = 1'b1;
            o_fd_flush  = 1'b1;
            o_da_bubble = 1'b1;
            w_state_nxt = S_RUN;
         end

         default: begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
         end
      endcase

      if (rst) begin
         o_pc_enable = 1'b0;
         o_pc_sel    = SEL_HOLD;
         o_fd_enable = 1'b0;
         o_fd_flush  = 1'b1;
         o_da_enable = 1'b0;
         o_da_bubble = 1'b1;
         o_int_step  = 1'b0;
         o_int_ack   = 1'b0;
      end
   end

endmodule
